// File: rtl/lieat_wbu_if.sv
// Write-back unit bus: EXU commit channel, long-completion channel,
// decode-stage dependency probe and the regfile write-back port.
interface lieat_wbu_if #(
  parameter int XLEN      = 32,
  parameter int REG_IDX   = 5,
  parameter int LONGI_PTR = 2
);
  // EXU commit channel
  logic                 exu_valid;
  logic                 exu_ready;
  logic [XLEN-1:0]      exu_pc;
  logic [REG_IDX-1:0]   exu_rd;
  logic                 exu_wen;
  logic [XLEN-1:0]      exu_data;
  logic                 exu_longi;
  logic                 exu_lsu;
  logic                 exu_ebreak;
  logic [LONGI_PTR-1:0] exu_itag;

  // Long-latency completion channel
  logic                 lng_valid;
  logic                 lng_ready;
  logic [LONGI_PTR-1:0] lng_itag;
  logic [XLEN-1:0]      lng_data;

  // Decode-stage RAW probe
  logic [REG_IDX-1:0]   dep_rs1;
  logic [REG_IDX-1:0]   dep_rs2;
  logic                 dep_hit;

  // Regfile write-back port
  logic [XLEN-1:0]      wb_pc;
  logic                 wb_valid;
  logic                 wb_en;
  logic [REG_IDX-1:0]   wb_rd;
  logic [XLEN-1:0]      wb_data;
  logic                 wb_lsu;
  logic                 wb_ebreak;
  logic                 longi_empty;

  // Upstream side: drives commits/completions, consumes write-back
  modport master (
    output exu_valid, exu_pc, exu_rd, exu_wen, exu_data, exu_longi, exu_lsu, exu_ebreak,
    input  exu_ready, exu_itag,
    output lng_valid, lng_itag, lng_data,
    input  lng_ready,
    output dep_rs1, dep_rs2,
    input  dep_hit,
    input  wb_pc, wb_valid, wb_en, wb_rd, wb_data, wb_lsu, wb_ebreak, longi_empty
  );

  // Write-back unit side
  modport slave (
    input  exu_valid, exu_pc, exu_rd, exu_wen, exu_data, exu_longi, exu_lsu, exu_ebreak,
    output exu_ready, exu_itag,
    input  lng_valid, lng_itag, lng_data,
    output lng_ready,
    input  dep_rs1, dep_rs2,
    output dep_hit,
    output wb_pc, wb_valid, wb_en, wb_rd, wb_data, wb_lsu, wb_ebreak, longi_empty
  );
endinterface

// File: rtl/lieat_wbu.sv
// Write-back unit: merges in-order EXU commits and out-of-order long
// completions onto a single registered regfile write port. Outstanding long
// instructions live in a small tag table used for allocation, WAW stalls and
// RAW dependency checks.
module lieat_wbu #(
  parameter int XLEN      = 32,
  parameter int REG_IDX   = 5,
  parameter int LONGI_NUM = 4,
  parameter int LONGI_PTR = 2
) (
  input  logic         clock,
  input  logic         reset,
  lieat_wbu_if.slave   bus
);

  // Tag table
  logic [LONGI_NUM-1:0] busy_reg;
  logic [LONGI_NUM-1:0] busy_next;
  logic [LONGI_NUM-1:0] wen_reg;
  logic [REG_IDX-1:0]   rd_reg [LONGI_NUM];

  // Per-entry comparison vectors
  logic [LONGI_NUM-1:0] waw_match;
  logic [LONGI_NUM-1:0] rs1_match;
  logic [LONGI_NUM-1:0] rs2_match;

  logic [LONGI_PTR-1:0] alloc_idx;
  logic                 full;
  logic                 waw;
  logic                 exu_ready_int;
  logic                 exu_fire;
  logic                 alloc_fire;
  logic                 lng_hit;
  logic                 free_fire;

  // Registered write-back outputs
  logic [XLEN-1:0]      wb_pc_reg;
  logic                 wb_valid_reg;
  logic                 wb_en_reg;
  logic [REG_IDX-1:0]   wb_rd_reg;
  logic [XLEN-1:0]      wb_data_reg;
  logic                 wb_lsu_reg;
  logic                 wb_ebreak_reg;
  logic                 longi_empty_reg;

  // Per-entry match logic against the commit rd and the decode sources
  for (genvar gi = 0; gi < LONGI_NUM; gi++) begin : g_match
    assign waw_match[gi] = busy_reg[gi] & wen_reg[gi] & (rd_reg[gi] == bus.exu_rd);
    assign rs1_match[gi] = busy_reg[gi] & (rd_reg[gi] == bus.dep_rs1);
    assign rs2_match[gi] = busy_reg[gi] & (rd_reg[gi] == bus.dep_rs2);
  end

  // Lowest-index free entry; scanning downward lets the lowest index win
  always_comb begin
    alloc_idx = '0;
    for (int i = LONGI_NUM - 1; i >= 0; i--) begin
      if (!busy_reg[i]) begin
        alloc_idx = LONGI_PTR'(i);
      end
    end
  end

  assign full = &busy_reg;

  // A commit that writes a register still owed by a long instruction must
  // wait, otherwise the late completion would overwrite the newer value.
  assign waw = bus.exu_wen & (|bus.exu_rd) & (|waw_match);

  // Completions take strict priority so alloc and free never share a cycle.
  assign exu_ready_int = ~bus.lng_valid & ~(bus.exu_longi & full) & ~waw;
  assign exu_fire      = bus.exu_valid & exu_ready_int;
  assign alloc_fire    = exu_fire & bus.exu_longi;
  assign lng_hit       = busy_reg[bus.lng_itag];
  assign free_fire     = bus.lng_valid & lng_hit;

  assign bus.exu_ready = exu_ready_int;
  assign bus.exu_itag  = alloc_idx;
  assign bus.lng_ready = 1'b1;

  // Conservative RAW check: an entry completing this cycle still reports a hit
  assign bus.dep_hit = ((|bus.dep_rs1) & (|rs1_match)) |
                       ((|bus.dep_rs2) & (|rs2_match));

  // Busy vector after this cycle's allocation or release
  always_comb begin
    busy_next = busy_reg;
    if (free_fire) begin
      busy_next[bus.lng_itag] = 1'b0;
    end else if (alloc_fire) begin
      busy_next[alloc_idx] = 1'b1;
    end
  end

  // Busy flags follow the computed next state
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy_reg <= '0;
    end else begin
      busy_reg <= busy_next;
    end
  end

  // Per-entry rd/wen capture on allocation
  for (genvar gi = 0; gi < LONGI_NUM; gi++) begin : g_entry
    // Record the destination of the long instruction given this tag
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        rd_reg[gi]  <= '0;
        wen_reg[gi] <= 1'b0;
      end else if (alloc_fire && (alloc_idx == LONGI_PTR'(gi))) begin
        rd_reg[gi]  <= bus.exu_rd;
        wen_reg[gi] <= bus.exu_wen;
      end
    end
  end

  // Write-back port: completion, commit or idle, one registered stage
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wb_pc_reg       <= '0;
      wb_valid_reg    <= 1'b0;
      wb_en_reg       <= 1'b0;
      wb_rd_reg       <= '0;
      wb_data_reg     <= '0;
      wb_lsu_reg      <= 1'b0;
      wb_ebreak_reg   <= 1'b0;
      longi_empty_reg <= 1'b1;
    end else begin
      longi_empty_reg <= ~(|busy_next);
      if (bus.lng_valid) begin
        // Completion: pc holds; a stale tag is consumed without a write
        wb_valid_reg <= 1'b0;
        if (lng_hit) begin
          wb_en_reg     <= wen_reg[bus.lng_itag] & (|rd_reg[bus.lng_itag]);
          wb_rd_reg     <= rd_reg[bus.lng_itag];
          wb_data_reg   <= bus.lng_data;
          wb_lsu_reg    <= 1'b0;
          wb_ebreak_reg <= 1'b0;
        end else begin
          wb_en_reg <= 1'b0;
        end
      end else if (exu_fire) begin
        wb_valid_reg  <= 1'b1;
        wb_pc_reg     <= bus.exu_pc;
        wb_rd_reg     <= bus.exu_rd;
        wb_lsu_reg    <= bus.exu_lsu;
        wb_ebreak_reg <= bus.exu_ebreak;
        if (bus.exu_longi) begin
          // Register write deferred to the completion
          wb_en_reg   <= 1'b0;
          wb_data_reg <= '0;
        end else begin
          wb_en_reg   <= bus.exu_wen & (|bus.exu_rd);
          wb_data_reg <= bus.exu_data;
        end
      end else begin
        wb_valid_reg <= 1'b0;
        wb_en_reg    <= 1'b0;
      end
    end
  end

  assign bus.wb_pc       = wb_pc_reg;
  assign bus.wb_valid    = wb_valid_reg;
  assign bus.wb_en       = wb_en_reg;
  assign bus.wb_rd       = wb_rd_reg;
  assign bus.wb_data     = wb_data_reg;
  assign bus.wb_lsu      = wb_lsu_reg;
  assign bus.wb_ebreak   = wb_ebreak_reg;
  assign bus.longi_empty = longi_empty_reg;

endmodule

// File: doc/lieat_wbu.md
Name: lieat_wbu

Overview:
- Write-back unit feeding the regfile write port (wb_* / longi_empty). It is the driving end of that interface.
- Accepts in-order commits from EXU and out-of-order completions from long-latency units (LSU loads, MDU).
- Tracks outstanding long instructions in a tag table and serialises all register writes onto one registered write-back port.
- Provides WAW ordering and RAW dependency checking against outstanding long results.

Parameters:
- XLEN, 32, data/pc width
- REG_IDX, 5, register index width
- LONGI_NUM, 4, outstanding long-instruction entries (power of 2, >=2)
- LONGI_PTR, 2, log2(LONGI_NUM), tag width

Ports:
- clock  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- exu_valid  in  1  EXU commit request
- exu_ready  out  1  commit accepted when valid&ready
- exu_pc  in  XLEN  committing pc
- exu_rd  in  REG_IDX  destination
- exu_wen  in  1  instruction writes rd
- exu_data  in  XLEN  result (ignored if exu_longi)
- exu_longi  in  1  result delivered later via lng_*
- exu_lsu  in  1  memory-access instr (difftest sync)
- exu_ebreak  in  1  ebreak commit
- exu_itag  out  LONGI_PTR  tag allocated to this long commit (valid when accepted)
- lng_valid  in  1  long completion
- lng_ready  out  1  constant 1
- lng_itag  in  LONGI_PTR  completing tag
- lng_data  in  XLEN  completion data
- dep_rs1, dep_rs2  in  REG_IDX  decode-stage sources
- dep_hit  out  1  a source nonzero and equal to an outstanding long rd
- wb_pc  out  XLEN  | wb_valid out 1 | wb_en out 1 | wb_rd out REG_IDX | wb_data out XLEN | wb_lsu out 1 | wb_ebreak out 1 | longi_empty out 1

Behaviour:
- Table state: per entry busy, rd, wen. Reset: all busy=0.
- Outputs all registered. Reset value is 0 for every wb_* output; longi_empty=1.
- Allocation: exu_itag = lowest-index non-busy entry (priority encoder). full = all busy.
- exu_ready = ~lng_valid & ~(exu_longi & full) & ~waw.
- waw = exu_wen & exu_rd!=0 & (some busy entry has rd==exu_rd and wen=1).
- lng has strict priority. Alloc and free never occur in the same cycle.
- Long completion (lng_valid, entry lng_itag busy), next cycle:
  - wb_valid=0, wb_en=entry.wen & entry.rd!=0, wb_rd=entry.rd, wb_data=lng_data, wb_lsu=0, wb_ebreak=0.
  - Entry busy cleared.
  - wb_pc holds its previous value.
- Completion to a non-busy tag: consumed, no state change, next cycle wb_valid=0, wb_en=0.
- EXU accept, next cycle:
  - wb_valid=1, wb_pc=exu_pc, wb_rd=exu_rd, wb_lsu=exu_lsu, wb_ebreak=exu_ebreak.
  - If exu_longi: wb_en=0, wb_data=0; entry exu_itag set busy with rd=exu_rd, wen=exu_wen.
  - Else: wb_en=exu_wen & exu_rd!=0, wb_data=exu_data.
- Idle cycle (neither accepted): wb_valid=0, wb_en=0; other wb_* hold their values.
- Latency: 1 cycle from handshake to wb_*. Back-to-back accepts allowed every cycle.
- longi_empty registered. It equals "no busy entry" after the cycle's update, aligned with wb_* of the same transaction.
- dep_hit combinational from current busy table. An entry completing this cycle still counts (conservative). x0 never hits.
- Reset mid-operation: table cleared, outstanding tags abandoned, outputs to reset values immediately (async). Completions arriving after reset deassertion hit non-busy tags and are dropped.

Test Plan:
- Reset then idle: wb_valid=0, wb_en=0, longi_empty=1, exu_ready=1, exu_itag=0.
- EXU commit pc=0x80000000, rd=5, data=0x1234, wen=1: next cycle wb_valid=1, wb_en=1, wb_rd=5, wb_data=0x1234. Same commit with rd=0: wb_en=0.
- Long load rd=7 accepted (itag 0) -> wb_valid=1, wb_en=0, longi_empty=0. dep_rs1=7 gives dep_hit=1. lng itag0 data=0xDEAD -> wb_en=1, wb_rd=7, wb_data=0xDEAD, wb_valid=0, longi_empty=1, dep_hit=0.
- Fill 4 long entries -> exu_itag 0,1,2,3, then exu_ready=0 for a long commit. Complete itag 2 -> next long allocates itag 2.
- Priority/WAW: lng_valid with exu_valid together -> exu_ready=0, completion written first, EXU accepted the following cycle. EXU wen rd=7 while rd=7 outstanding -> stalled until completion.
- Assert reset with 2 entries busy -> longi_empty=1 immediately. Stale lng itag1 afterwards -> wb_en=0.
